// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet scheduler.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_IN_PKT   = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  localparam int IPG_CYCLES_DEF    = 4;
  localparam int START_TIMEOUT_DEF = 64;

  // Source id doubles as the TX mux select value.
  localparam logic SRC_TO = 1'b0;
  localparam logic SRC_DT = 1'b1;

endpackage

// File: rtl/usb_tx_sched_cnt.sv
// Clearable up-counter with terminal-compare, shared by timeout and gap timing.
module usb_tx_sched_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/usb_tx_sched.sv
// USB TX packet scheduler: fixed-priority grant (TO over DT), mux select held
// for the whole packet, SOP start timeout and inter-packet gap.
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int IPG_CYCLES    = IPG_CYCLES_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_to,
  input  logic req_dt,
  input  logic tx_sop_fire,
  input  logic tx_eop_en,
  output logic tx_data_on,
  output logic gnt_to,
  output logic gnt_dt,
  output logic done_to,
  output logic done_dt,
  output logic timeout_err,
  output logic busy
);

  // Terminal values: timeout fires when WAIT_SOP has counted START_TIMEOUT-1,
  // gap ends after IPG_CYCLES cycles in GAP (GAP is skipped when 0).
  localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IPG_TERM = CNT_W'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);

  state_e state_q, state_d;
  logic   data_on_q, data_on_d;
  logic   gnt_to_q, gnt_to_d, gnt_dt_q, gnt_dt_d;
  logic   done_to_q, done_to_d, done_dt_q, done_dt_d;
  logic   tmo_q, tmo_d;

  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_term, cnt_val;
  logic             complete, go_gap;

  usb_tx_sched_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_i (cnt_term),
    .cnt_o  (cnt_val),
    .tc_o   (cnt_tc)
  );

  // Next-state, grant/done decode and counter control.
  always_comb begin
    state_d   = state_q;
    data_on_d = data_on_q;
    gnt_to_d  = 1'b0;
    gnt_dt_d  = 1'b0;
    done_to_d = 1'b0;
    done_dt_d = 1'b0;
    tmo_d     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_term  = TMO_TERM;
    complete  = 1'b0;
    go_gap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_to) begin
          gnt_to_d  = 1'b1;
          data_on_d = SRC_TO;
          cnt_clr   = 1'b1;
          state_d   = ST_WAIT_SOP;
        end else if (req_dt) begin
          gnt_dt_d  = 1'b1;
          data_on_d = SRC_DT;
          cnt_clr   = 1'b1;
          state_d   = ST_WAIT_SOP;
        end
      end
      ST_WAIT_SOP: begin
        cnt_inc = 1'b1;
        // EOP (with or without SOP) completes; SOP alone starts the packet.
        if (tx_eop_en)        complete = 1'b1;
        else if (tx_sop_fire) state_d  = ST_IN_PKT;
        else if (cnt_tc) begin
          tmo_d  = 1'b1;
          go_gap = 1'b1;
        end
      end
      ST_IN_PKT: begin
        if (tx_eop_en) complete = 1'b1;
      end
      ST_GAP: begin
        cnt_term = IPG_TERM;
        if (cnt_tc) state_d = ST_IDLE;
        else        cnt_inc = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      done_to_d = (data_on_q == SRC_TO);
      done_dt_d = (data_on_q == SRC_DT);
      go_gap    = 1'b1;
    end
    if (go_gap) begin
      cnt_clr = 1'b1;
      state_d = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_on_q <= 1'b0;
      gnt_to_q  <= 1'b0;
      gnt_dt_q  <= 1'b0;
      done_to_q <= 1'b0;
      done_dt_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_on_q <= data_on_d;
      gnt_to_q  <= gnt_to_d;
      gnt_dt_q  <= gnt_dt_d;
      done_to_q <= done_to_d;
      done_dt_q <= done_dt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tx_data_on  = data_on_q;
  assign gnt_to      = gnt_to_q;
  assign gnt_dt      = gnt_dt_q;
  assign done_to     = done_to_q;
  assign done_dt     = done_dt_q;
  assign timeout_err = tmo_q;
  assign busy        = (state_q != ST_IDLE);

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: default DUT plus an IPG_CYCLES=0 DUT.
module tb_usb_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic rt = 0, rd = 0, sop = 0, eop = 0;
  logic on, g_to, g_dt, d_to, d_dt, tmo, bsy;
  // IPG_CYCLES=0 DUT
  logic rt0 = 0, rd0 = 0, sop0 = 0, eop0 = 0;
  logic on0, g_to0, g_dt0, d_to0, d_dt0, tmo0, bsy0;

  usb_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .req_to(rt), .req_dt(rd),
    .tx_sop_fire(sop), .tx_eop_en(eop), .tx_data_on(on),
    .gnt_to(g_to), .gnt_dt(g_dt), .done_to(d_to), .done_dt(d_dt),
    .timeout_err(tmo), .busy(bsy)
  );

  usb_tx_sched #(.IPG_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_to(rt0), .req_dt(rd0),
    .tx_sop_fire(sop0), .tx_eop_en(eop0), .tx_data_on(on0),
    .gnt_to(g_to0), .gnt_dt(g_dt0), .done_to(d_to0), .done_dt(d_dt0),
    .timeout_err(tmo0), .busy(bsy0)
  );

  // Output vector order: {gnt_to, gnt_dt, done_to, done_dt, timeout_err, busy, tx_data_on}
  logic [6:0] o, o0;
  assign o  = {g_to,  g_dt,  d_to,  d_dt,  tmo,  bsy,  on};
  assign o0 = {g_to0, g_dt0, d_to0, d_dt0, tmo0, bsy0, on0};

  typedef struct packed {
    logic [3:0] in;   // {req_to, req_dt, sop, eop}
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[29];
  int total = 0, bad = 0;
  int errs;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (gto gdt dto ddt tmo busy on)", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; return just after the edge so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Data packet, then TO/DT contention, then DT EOP-without-SOP.
    tbl[0] = {4'b0100, 7'b0100011};
    for (int i = 1; i <= 9; i++) tbl[i] = {(i == 3) ? 4'b0010 : 4'b0000, 7'b0000011};
    tbl[10] = {4'b0001, 7'b0001011};
    for (int i = 11; i <= 13; i++) tbl[i] = {4'b0000, 7'b0000011};
    tbl[14] = {4'b0000, 7'b0000001};
    tbl[15] = {4'b1100, 7'b1000010};
    tbl[16] = {4'b0100, 7'b0000010};
    tbl[17] = {4'b0111, 7'b0010010};
    for (int i = 18; i <= 20; i++) tbl[i] = {4'b0100, 7'b0000010};
    tbl[21] = {4'b0100, 7'b0000000};
    tbl[22] = {4'b0100, 7'b0100011};
    tbl[23] = {4'b0000, 7'b0000011};
    tbl[24] = {4'b0001, 7'b0001011};
    for (int i = 25; i <= 27; i++) tbl[i] = {4'b0000, 7'b0000011};
    tbl[28] = {4'b0000, 7'b0000001};

    #3;
    chk("reset_state", o, 7'b0000000);
    chk("reset_state_ipg0", o0, 7'b0000000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      {rt, rd, sop, eop} = tbl[i].in;
      step();
      chk($sformatf("vec%0d", i), o, tbl[i].exp);
    end
    {rt, rd, sop, eop} = 4'b0000;

    // Timeout: TO granted, no SOP ever.
    rt = 1;
    step();
    chk("tmo_grant", o, 7'b1000010);
    rt = 0;
    errs = 0;
    for (int k = 1; k < 64; k++) begin
      step();
      if (tmo || d_to || !bsy || on) errs++;
    end
    chk_int("tmo_early", errs, 0);
    step();
    chk("tmo_pulse", o, 7'b0000110);
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o != 7'b0000010) errs++;
    end
    chk_int("tmo_gap", errs, 0);
    step();
    chk("tmo_idle", o, 7'b0000000);

    // TO request during DT packet: select held, TO waits for the gap.
    rd = 1;
    step();
    chk("hold_gnt_dt", o, 7'b0100011);
    rd = 0;
    step();
    sop = 1;
    step();
    sop = 0;
    rt = 1;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (!on || g_to || !bsy) errs++;
    end
    chk_int("hold_in_pkt", errs, 0);
    eop = 1;
    step();
    eop = 0;
    chk("hold_done_dt", o, 7'b0001011);
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o != 7'b0000011) errs++;
    end
    chk_int("hold_gap", errs, 0);
    step();
    chk("hold_idle", o, 7'b0000001);
    step();
    chk("hold_gnt_to", o, 7'b1000010);
    rt = 0;
    step();
    eop = 1;
    step();
    eop = 0;
    chk("hold_done_to", o, 7'b0010010);
    repeat (4) step();
    chk("hold_end", o, 7'b0000000);

    // Async reset in IN_PKT of a DT packet, request held across reset.
    rd = 1;
    step();
    chk("rst_gnt", o, 7'b0100011);
    step();
    sop = 1;
    step();
    sop = 0;
    step();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", o, 7'b0000000);
    eop = 1;
    step();
    chk("rst_hold", o, 7'b0000000);
    eop = 0;
    rst_n = 1'b1;
    step();
    chk("rst_regrant", o, 7'b0100011);
    rd = 0;
    sop = 1;
    eop = 1;
    step();
    sop = 0;
    eop = 0;
    chk("rst_single_beat", o, 7'b0001011);
    repeat (4) step();
    chk("rst_end", o, 7'b0000001);

    // IPG_CYCLES=0: single-beat packet, straight back to IDLE, back-to-back grant.
    rd0 = 1;
    step();
    chk("ipg0_gnt", o0, 7'b0100011);
    sop0 = 1;
    eop0 = 1;
    step();
    sop0 = 0;
    eop0 = 0;
    chk("ipg0_done", o0, 7'b0001001);
    step();
    chk("ipg0_b2b", o0, 7'b0100011);
    rd0 = 0;
    step();
    eop0 = 1;
    step();
    eop0 = 0;
    chk("ipg0_done2", o0, 7'b0001001);
    step();
    chk("ipg0_idle", o0, 7'b0000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
